// File: rtl/fetch_decode.sv
// Front-end of the 16-bit LC-3-style core: instruction pointer, single
// outstanding instruction fetch, and decode into the operand bundle consumed
// by execute over a valid/ready handshake. Execute can redirect fetch at any
// time. The {mode_flag, opcode} class is exposed as op_type because "type" is
// a reserved word.
module fetch_decode #(
  parameter logic [15:0] RESET_IP = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] inst,
  output logic [4:0]  op_type,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic [15:0] imm,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [15:0] IP,
  input  logic        redirect,
  input  logic [15:0] redirect_ip
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  typ;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [15:0] imm;
    logic [2:0]  nzp;
  } dec_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic        discard, discard_nx;
  logic        started;
  logic        load;
  dec_t        dec_q;
  logic [15:0] inst_q;
  logic [15:0] ip_q;

  // Field extraction for one instruction word; unused fields stay zero.
  function automatic dec_t decode(input logic [15:0] w);
    dec_t d;
    d     = '0;
    d.typ = {1'b0, w[15:12]};
    case (w[15:12])
      4'b0001, 4'b0101: begin
        d.dr     = w[11:9];
        d.sr1    = w[8:6];
        d.typ[4] = w[5];
        if (w[5]) d.imm = {{11{w[4]}}, w[4:0]};
        else      d.sr2 = w[2:0];
      end
      4'b1001: begin
        d.dr  = w[11:9];
        d.sr1 = w[8:6];
      end
      4'b0000: begin
        d.nzp = w[11:9];
        d.imm = {{7{w[8]}}, w[8:0]};
      end
      4'b0010, 4'b1010, 4'b1110: begin
        d.dr  = w[11:9];
        d.imm = {{7{w[8]}}, w[8:0]};
      end
      4'b0011, 4'b1011: begin
        d.sr2 = w[11:9];
        d.imm = {{7{w[8]}}, w[8:0]};
      end
      4'b0110: begin
        d.dr  = w[11:9];
        d.sr1 = w[8:6];
        d.imm = {{10{w[5]}}, w[5:0]};
      end
      4'b0111: begin
        d.sr2 = w[11:9];
        d.sr1 = w[8:6];
        d.imm = {{10{w[5]}}, w[5:0]};
      end
      4'b1100: begin
        d.sr1 = w[8:6];
      end
      4'b0100: begin
        d.typ[4] = w[11];
        d.dr     = 3'd7;
        if (w[11]) d.imm = {{5{w[10]}}, w[10:0]};
        else       d.sr1 = w[8:6];
      end
      4'b1111: begin
        d.dr  = 3'd7;
        d.imm = {8'h00, w[7:0]};
      end
      default: begin
        // RTI and reserved carry only the opcode class
      end
    endcase
    return d;
  endfunction

  // Hold the first request off for one edge after reset release so imem_req
  // never rises combinationally with the reset deassertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) started <= 1'b0;
    else     started <= 1'b1;
  end

  // Control state: FSM, fetch pointer and the drop-next-response flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_IP;
      discard <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      discard <= discard_nx;
    end
  end

  // Next-state: redirect wins over every other event in every state.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    discard_nx = discard;
    load       = 1'b0;
    case (state)
      S_REQ: begin
        if (started) begin
          state_nx = S_WAIT;
          if (redirect) begin
            pc_nx      = redirect_ip;
            discard_nx = 1'b1;
          end
        end else if (redirect) begin
          pc_nx = redirect_ip;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect || discard) begin
            state_nx   = S_REQ;
            discard_nx = 1'b0;
            if (redirect) pc_nx = redirect_ip;
          end else begin
            load     = 1'b1;
            pc_nx    = pc + 16'd1;
            state_nx = S_VALID;
          end
        end else if (redirect) begin
          pc_nx      = redirect_ip;
          discard_nx = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_nx    = redirect_ip;
          state_nx = S_REQ;
        end else if (dec_ready) begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

  // Decoded bundle register: captured once per accepted fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q  <= '0;
      inst_q <= '0;
      ip_q   <= '0;
    end else if (load) begin
      dec_q  <= decode(imem_rdata);
      inst_q <= imem_rdata;
      ip_q   <= pc + 16'd1;
    end
  end

  assign imem_req  = (state == S_REQ) && started;
  assign imem_addr = imem_req ? pc : 16'h0000;
  assign dec_valid = (state == S_VALID);
  assign inst      = inst_q;
  assign op_type   = dec_q.typ;
  assign SR1       = dec_q.sr1;
  assign SR2       = dec_q.sr2;
  assign DR        = dec_q.dr;
  assign imm       = dec_q.imm;
  assign n         = dec_q.nzp[2];
  assign z         = dec_q.nzp[1];
  assign p         = dec_q.nzp[0];
  assign IP        = ip_q;

endmodule
